fpu_ss_regfile_sb: RTL

FPU_SS_REGFILE_SB -- requirements
Module: fpu_ss_regfile_sb

---
 rtl/fpu_ss_regfile_sb.sv | 104 ++++++++++
 1 files changed

// File: rtl/fpu_ss_regfile_sb.sv
// Multi-port FP register file with a per-register busy scoreboard.
// Define FPU_SS_RF_BYPASS_EN to forward same-cycle write data to the read ports.
module fpu_ss_regfile_sb #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_WORDS  = 32,
    parameter int unsigned NUM_RPORTS = 3,
    parameter int unsigned NUM_WPORTS = 2
) (
    input  logic                                           clk_i,
    input  logic                                           rst_i,
    input  logic [NUM_RPORTS-1:0][$clog2(NUM_WORDS)-1:0]   raddr_i,
    output logic [NUM_RPORTS-1:0][DATA_WIDTH-1:0]          rdata_o,
    output logic [NUM_RPORTS-1:0]                          rbusy_o,
    input  logic [NUM_WPORTS-1:0][$clog2(NUM_WORDS)-1:0]   waddr_i,
    input  logic [NUM_WPORTS-1:0][DATA_WIDTH-1:0]          wdata_i,
    input  logic [NUM_WPORTS-1:0]                          we_i,
    input  logic                                           rsv_valid_i,
    input  logic [$clog2(NUM_WORDS)-1:0]                   rsv_addr_i,
    output logic                                           rsv_ready_o,
    input  logic                                           flush_i,
    output logic [NUM_WORDS-1:0]                           busy_o
);

    localparam int unsigned AW = $clog2(NUM_WORDS);

    logic [DATA_WIDTH-1:0] mem_q [NUM_WORDS];
    logic [DATA_WIDTH-1:0] mem_d [NUM_WORDS];
    logic [NUM_WORDS-1:0]  busy_q;
    logic [NUM_WORDS-1:0]  busy_d;
    logic                  rsv_ready;

    assign rsv_ready   = rsv_valid_i & ~busy_q[rsv_addr_i] & ~flush_i;
    assign rsv_ready_o = rsv_ready;
    assign busy_o      = busy_q;

    // Ascending port order lets the highest-index writer win on address collisions.
    always_comb begin
        mem_d = mem_q;
        for (int unsigned p = 0; p < NUM_WPORTS; p++) begin
            if (we_i[p]) begin
                mem_d[waddr_i[p]] = wdata_i[p];
            end
        end
    end

    // Write clears first, then an accepted reservation re-sets its bit.
    always_comb begin
        busy_d = busy_q;
        for (int unsigned p = 0; p < NUM_WPORTS; p++) begin
            if (we_i[p]) begin
                busy_d[waddr_i[p]] = 1'b0;
            end
        end
        if (flush_i) begin
            busy_d = '0;
        end
        if (rsv_ready) begin
            busy_d[rsv_addr_i] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < NUM_WORDS; i++) begin
                mem_q[i] <= '0;
            end
            busy_q <= '0;
        end else begin
            mem_q  <= mem_d;
            busy_q <= busy_d;
        end
    end

`ifdef FPU_SS_RF_BYPASS_EN
    // Forwarding is suppressed during reset so read data reads back as zero.
    always_comb begin
        rdata_o = '0;
        rbusy_o = '0;
        for (int unsigned r = 0; r < NUM_RPORTS; r++) begin
            rdata_o[r] = mem_q[raddr_i[r]];
            rbusy_o[r] = busy_q[raddr_i[r]];
            for (int unsigned p = 0; p < NUM_WPORTS; p++) begin
                if (we_i[p] && !rst_i && (waddr_i[p] == raddr_i[r])) begin
                    rdata_o[r] = wdata_i[p];
                    rbusy_o[r] = rsv_ready && (rsv_addr_i == raddr_i[r]);
                end
            end
        end
    end
`else
    always_comb begin
        rdata_o = '0;
        rbusy_o = '0;
        for (int unsigned r = 0; r < NUM_RPORTS; r++) begin
            rdata_o[r] = mem_q[raddr_i[r]];
            rbusy_o[r] = busy_q[raddr_i[r]];
        end
    end
`endif

    logic unused_aw;
    assign unused_aw = (AW == 0);

endmodule
